// File: rtl/cnt_updown_re_if.sv
// Control and status bundle for the loadable up/down counter.
// Master drives count/load controls; slave (the counter) returns Q and its flags.
interface cnt_updown_re_if #(
  parameter int WIDTH = 8
);
  logic             E;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic             UP;
  logic [WIDTH-1:0] Q;
  logic             TC;
  logic             CO;
  logic             OVF;

  modport master (output E, LD, D, UP, input Q, TC, CO, OVF);
  modport slave  (input E, LD, D, UP, output Q, TC, CO, OVF);
endinterface

// File: rtl/cnt_updown_re.sv
// Parametrised loadable up/down counter with wrap/saturate modes and a
// selectable active clock edge; carry-out of the ripple chain is the terminal count.
module cnt_updown_re #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               SATURATE    = 0,
  parameter int               NEG_EDGE    = 0
) (
  input  logic            C,
  input  logic            R,
  cnt_updown_re_if.slave  bus
);

  logic [WIDTH-1:0] r_q;
  logic             r_co;
  logic             r_ovf;

  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_sum;
  logic             w_tc;
  logic [WIDTH-1:0] w_q_next;
  logic             w_co_next;
  logic             w_ovf_next;

  // Propagate is Q for increment and ~Q for decrement, so one chain serves both.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi = gi + 1) begin : g_prop
      assign w_p[gi] = r_q[gi] ^ ~bus.UP;
    end
  endgenerate

  always_comb begin
    logic v_carry;
    v_carry = 1'b1;
    w_sum   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i] = r_q[i] ^ v_carry;
      v_carry  = v_carry & w_p[i];
    end
    w_tc = v_carry;
  end

  always_comb begin
    w_q_next   = r_q;
    w_co_next  = 1'b0;
    w_ovf_next = r_ovf;
    if (bus.E) begin
      if (bus.LD) begin
        w_q_next   = bus.D;
        w_ovf_next = 1'b0;
      end else if (w_tc) begin
        w_co_next  = 1'b1;
        w_ovf_next = 1'b1;
        w_q_next   = (SATURATE != 0) ? r_q : w_sum;
      end else begin
        w_q_next = w_sum;
      end
    end
  end

  generate
    if (NEG_EDGE != 0) begin : g_neg
      always_ff @(negedge C or negedge R) begin
        if (!R) begin
          r_q   <= RESET_VALUE;
          r_co  <= 1'b0;
          r_ovf <= 1'b0;
        end else begin
          r_q   <= w_q_next;
          r_co  <= w_co_next;
          r_ovf <= w_ovf_next;
        end
      end
    end else begin : g_pos
      always_ff @(posedge C or negedge R) begin
        if (!R) begin
          r_q   <= RESET_VALUE;
          r_co  <= 1'b0;
          r_ovf <= 1'b0;
        end else begin
          r_q   <= w_q_next;
          r_co  <= w_co_next;
          r_ovf <= w_ovf_next;
        end
      end
    end
  endgenerate

  assign bus.Q   = r_q;
  assign bus.TC  = w_tc;
  assign bus.CO  = r_co;
  assign bus.OVF = r_ovf;

endmodule

// File: tb/tb_cnt_updown_re.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor
// pops and compares them against three counter configurations.
module tb_cnt_updown_re;

  logic clk = 1'b0;
  logic r_a, r_b, r_c;

  always #5 clk = ~clk;

  cnt_updown_re_if #(.WIDTH(8)) if_a ();
  cnt_updown_re_if #(.WIDTH(8)) if_b ();
  cnt_updown_re_if #(.WIDTH(4)) if_c ();

  cnt_updown_re #(.WIDTH(8), .RESET_VALUE(8'h5A), .SATURATE(0), .NEG_EDGE(0))
    dut_a (.C(clk), .R(r_a), .bus(if_a));
  cnt_updown_re #(.WIDTH(8), .RESET_VALUE(8'h00), .SATURATE(1), .NEG_EDGE(0))
    dut_b (.C(clk), .R(r_b), .bus(if_b));
  cnt_updown_re #(.WIDTH(4), .RESET_VALUE(4'h0), .SATURATE(0), .NEG_EDGE(1))
    dut_c (.C(clk), .R(r_c), .bus(if_c));

  typedef struct {
    int         dut;
    logic [7:0] q;
    logic       tc;
    logic       co;
    logic       ovf;
    string      name;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic expect_out(input int dut, input logic [7:0] q, input logic tc,
                            input logic co, input logic ovf, input string name);
    exp_t e;
    e.dut = dut; e.q = q; e.tc = tc; e.co = co; e.ovf = ovf; e.name = name;
    sb.push_back(e);
    ->sample_ev;
  endtask

  // Monitor
  initial begin
    exp_t       e;
    logic [7:0] aq;
    logic       atc, aco, aovf;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.dut)
          0:       begin aq = if_a.Q;         atc = if_a.TC; aco = if_a.CO; aovf = if_a.OVF; end
          1:       begin aq = if_b.Q;         atc = if_b.TC; aco = if_b.CO; aovf = if_b.OVF; end
          default: begin aq = {4'h0, if_c.Q}; atc = if_c.TC; aco = if_c.CO; aovf = if_c.OVF; end
        endcase
        vectors++;
        if (aq !== e.q || atc !== e.tc || aco !== e.co || aovf !== e.ovf) begin
          miscompares++;
          $display("FAIL %s dut%0d: got Q=%h TC=%b CO=%b OVF=%b, want Q=%h TC=%b CO=%b OVF=%b",
                   e.name, e.dut, aq, atc, aco, aovf, e.q, e.tc, e.co, e.ovf);
        end else begin
          $display("ok   %s dut%0d: Q=%h TC=%b CO=%b OVF=%b @%0t",
                   e.name, e.dut, aq, atc, aco, aovf, $time);
        end
      end
    end
  end

  logic [7:0] up_q   [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
  logic       up_tc  [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
  logic       up_co  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic       up_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic [7:0] dn_q   [4] = '{8'h01, 8'h00, 8'h00, 8'h00};
  logic       dn_tc  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic       dn_co  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
  logic       dn_ovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};

  // Stimulus
  initial begin
    r_a = 1'b0; r_b = 1'b0; r_c = 1'b0;
    if_a.E = 1'b0; if_a.LD = 1'b0; if_a.D = 8'h00; if_a.UP = 1'b1;
    if_b.E = 1'b0; if_b.LD = 1'b0; if_b.D = 8'h00; if_b.UP = 1'b0;
    if_c.E = 1'b0; if_c.LD = 1'b0; if_c.D = 4'h0; if_c.UP = 1'b1;

    // Reset held, then release away from any edge and hold with E=0
    repeat (2) @(posedge clk);
    #1 expect_out(0, 8'h5A, 1'b0, 1'b0, 1'b0, "rst_hold");
    @(negedge clk); #2;
    r_a = 1'b1; r_b = 1'b1; r_c = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1 expect_out(0, 8'h5A, 1'b0, 1'b0, 1'b0, "en0_hold");
    end

    // Up-count wrap
    @(negedge clk); if_a.E = 1'b1; if_a.LD = 1'b1; if_a.D = 8'hFD; if_a.UP = 1'b1;
    @(posedge clk); #1 expect_out(0, 8'hFD, 1'b0, 1'b0, 1'b0, "wrap_load");
    @(negedge clk); if_a.LD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 expect_out(0, up_q[i], up_tc[i], up_co[i], up_ovf[i], "wrap_cnt");
    end

    // Load priority and direction change
    @(negedge clk); if_a.LD = 1'b1; if_a.D = 8'h40;
    @(posedge clk); #1 expect_out(0, 8'h40, 1'b0, 1'b0, 1'b0, "ld_40");
    @(negedge clk); if_a.D = 8'h00; if_a.UP = 1'b0;
    @(posedge clk); #1 expect_out(0, 8'h00, 1'b1, 1'b0, 1'b0, "ld_prio");
    @(negedge clk); if_a.UP = 1'b1; if_a.LD = 1'b0;
    #1 expect_out(0, 8'h00, 1'b0, 1'b0, 1'b0, "tc_comb");
    @(posedge clk); #1 expect_out(0, 8'h01, 1'b0, 1'b0, 1'b0, "dir_up");

    // Asynchronous reset mid-count
    @(negedge clk); if_a.LD = 1'b1; if_a.D = 8'h32;
    @(posedge clk); #1 expect_out(0, 8'h32, 1'b0, 1'b0, 1'b0, "ld_32");
    @(negedge clk); if_a.LD = 1'b0;
    @(posedge clk); #1 expect_out(0, 8'h33, 1'b0, 1'b0, 1'b0, "cnt_33");
    #2 r_a = 1'b0;
    #1 expect_out(0, 8'h5A, 1'b0, 1'b0, 1'b0, "async_rst");
    @(posedge clk); #1 expect_out(0, 8'h5A, 1'b0, 1'b0, 1'b0, "rst_edge_hold");
    @(negedge clk); r_a = 1'b1;
    @(posedge clk); #1 expect_out(0, 8'h5B, 1'b0, 1'b0, 1'b0, "resume");
    @(negedge clk); if_a.E = 1'b0;

    // Down-count saturate
    @(negedge clk); if_b.E = 1'b1; if_b.LD = 1'b1; if_b.D = 8'h02; if_b.UP = 1'b0;
    @(posedge clk); #1 expect_out(1, 8'h02, 1'b0, 1'b0, 1'b0, "sat_load");
    @(negedge clk); if_b.LD = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 expect_out(1, dn_q[i], dn_tc[i], dn_co[i], dn_ovf[i], "sat_cnt");
    end
    @(negedge clk); if_b.LD = 1'b1; if_b.D = 8'h10;
    @(posedge clk); #1 expect_out(1, 8'h10, 1'b0, 1'b0, 1'b0, "sat_reload");
    @(negedge clk); if_b.E = 1'b0; if_b.LD = 1'b0;

    // Negative-edge variant: drive after rising edges, check after both edges
    @(posedge clk); #1 if_c.E = 1'b1; if_c.LD = 1'b1; if_c.D = 4'hE; if_c.UP = 1'b1;
    @(negedge clk); #1 expect_out(2, 8'h0E, 1'b0, 1'b0, 1'b0, "neg_load");
    @(posedge clk); #1 expect_out(2, 8'h0E, 1'b0, 1'b0, 1'b0, "neg_rise_hold");
    if_c.LD = 1'b0;
    @(negedge clk); #1 expect_out(2, 8'h0F, 1'b1, 1'b0, 1'b0, "neg_cnt_F");
    @(posedge clk); #1 expect_out(2, 8'h0F, 1'b1, 1'b0, 1'b0, "neg_rise_F");
    @(negedge clk); #1 expect_out(2, 8'h00, 1'b0, 1'b1, 1'b1, "neg_wrap");
    @(posedge clk); #1 expect_out(2, 8'h00, 1'b0, 1'b1, 1'b1, "neg_rise_0");
    @(negedge clk); #1 expect_out(2, 8'h01, 1'b0, 1'b0, 1'b1, "neg_cnt_1");

    #20;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
